// File: rtl/node_param.sv
// Packet node. An outbound FIFO feeds a serialiser that sends 4 bytes, MSB first. A deserialiser
// rebuilds inbound packets and filters them by destination ID.
module node_param #(
  parameter logic [3:0]  NODEID     = 4'd0,
  parameter int unsigned DEPTH      = 4,
  parameter bit          ADDR_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_avail,
  output logic        cQ_full,
  output logic [31:0] pkt_out,
  output logic        pkt_out_avail,
  input  logic        free_outbound,
  output logic        put_outbound,
  output logic [7:0]  payload_outbound,
  output logic        free_inbound,
  input  logic        put_inbound,
  input  logic [7:0]  payload_inbound,
  output logic        rx_drop
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {TxIdle, TxSend} tx_state_e;
  typedef enum logic {RxIdle, RxRecv} rx_state_e;

  // Outbound FIFO
  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en, pop;
  logic [31:0]     head;

  // TX state
  tx_state_e   tx_state_q;
  logic [1:0]  tx_idx_q;
  logic [31:0] tx_shift_q;
  logic        put_q;
  logic [7:0]  payload_q;

  // RX state
  rx_state_e   rx_state_q;
  logic [1:0]  rx_idx_q;
  logic [31:0] asm_q, asm_d;
  logic [31:0] pkt_out_q;
  logic        pkt_avail_q;
  logic        drop_q;
  logic        free_q;

  assign cQ_full = (count_q == CntW'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  // Full is taken from the registered count, so a pop in the same cycle cannot make room.
  assign wr_en   = pkt_in_avail && !cQ_full;
  assign pop     = (tx_state_q == TxIdle) && free_outbound && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately not reset; the count gates every read.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= pkt_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Serialiser: byte 0 leaves straight from the FIFO head, later bytes from a rotating copy.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      tx_state_q <= TxIdle;
      tx_idx_q   <= 2'd0;
      tx_shift_q <= '0;
      put_q      <= 1'b0;
      payload_q  <= '0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (pop) begin
            tx_shift_q <= {head[23:0], head[31:24]};
            payload_q  <= head[31:24];
            put_q      <= 1'b1;
            tx_idx_q   <= 2'd0;
            tx_state_q <= TxSend;
          end else begin
            put_q <= 1'b0;
          end
        end
        TxSend: begin
          if (tx_idx_q == 2'd3) begin
            put_q      <= 1'b0;
            tx_state_q <= TxIdle;
          end else begin
            payload_q  <= tx_shift_q[31:24];
            tx_shift_q <= {tx_shift_q[23:0], tx_shift_q[31:24]};
            put_q      <= 1'b1;
            tx_idx_q   <= tx_idx_q + 2'd1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign put_outbound     = put_q;
  assign payload_outbound = payload_q;

  // Drop the incoming byte into its slot of the assembly word.
  always_comb begin
    asm_d = asm_q;
    unique case (rx_idx_q)
      2'd0: asm_d[31:24] = payload_inbound;
      2'd1: asm_d[23:16] = payload_inbound;
      2'd2: asm_d[15:8]  = payload_inbound;
      2'd3: asm_d[7:0]   = payload_inbound;
      default: asm_d = asm_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      rx_state_q  <= RxIdle;
      rx_idx_q    <= 2'd0;
      asm_q       <= '0;
      pkt_out_q   <= '0;
      pkt_avail_q <= 1'b0;
      drop_q      <= 1'b0;
      free_q      <= 1'b0;
    end else begin
      pkt_avail_q <= 1'b0;
      drop_q      <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (put_inbound) begin
            asm_q      <= asm_d;
            rx_idx_q   <= 2'd1;
            rx_state_q <= RxRecv;
            free_q     <= 1'b0;
          end else begin
            free_q <= 1'b1;
          end
        end
        RxRecv: begin
          if (!put_inbound) begin
            drop_q     <= 1'b1;
            rx_idx_q   <= 2'd0;
            rx_state_q <= RxIdle;
            free_q     <= 1'b1;
          end else if (rx_idx_q == 2'd3) begin
            asm_q      <= asm_d;
            rx_idx_q   <= 2'd0;
            rx_state_q <= RxIdle;
            free_q     <= 1'b1;
            if (!ADDR_CHECK || (asm_q[27:24] == NODEID)) begin
              pkt_out_q   <= asm_d;
              pkt_avail_q <= 1'b1;
            end else begin
              drop_q <= 1'b1;
            end
          end else begin
            asm_q    <= asm_d;
            rx_idx_q <= rx_idx_q + 2'd1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign pkt_out       = pkt_out_q;
  assign pkt_out_avail = pkt_avail_q;
  assign rx_drop       = drop_q;
  assign free_inbound  = free_q;

endmodule

// File: tb/tb_node_param.sv
// Directed bench for node_param: outbound bytes and inbound packets are checked against
// scoreboard queues filled when the stimulus is driven.
module tb_node_param;

  logic        clock;
  logic        reset_b;
  logic [31:0] pkt_in;
  logic        pkt_in_avail;
  logic        free_outbound;
  logic        put_inbound;
  logic [7:0]  payload_inbound;

  logic        cq_full, pkt_avail, put_out, free_in, drop;
  logic [31:0] pkt_out;
  logic [7:0]  payload_out;

  logic        cq_full0, pkt_avail0, put_out0, free_in0, drop0;
  logic [31:0] pkt_out0;
  logic [7:0]  payload_out0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_drop   = 0;
  int n_drop0  = 0;
  int n_put0   = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] rx0_q[$];
  logic [31:0] pk[6];

  node_param #(.NODEID(4'd3), .DEPTH(4), .ADDR_CHECK(1'b1)) dut (
    .clock            (clock),
    .reset_b          (reset_b),
    .pkt_in           (pkt_in),
    .pkt_in_avail     (pkt_in_avail),
    .cQ_full          (cq_full),
    .pkt_out          (pkt_out),
    .pkt_out_avail    (pkt_avail),
    .free_outbound    (free_outbound),
    .put_outbound     (put_out),
    .payload_outbound (payload_out),
    .free_inbound     (free_in),
    .put_inbound      (put_inbound),
    .payload_inbound  (payload_inbound),
    .rx_drop          (drop)
  );

  // Same node without address filtering; its outbound side stays unused.
  node_param #(.NODEID(4'd3), .DEPTH(4), .ADDR_CHECK(1'b0)) dut0 (
    .clock            (clock),
    .reset_b          (reset_b),
    .pkt_in           (pkt_in),
    .pkt_in_avail     (1'b0),
    .cQ_full          (cq_full0),
    .pkt_out          (pkt_out0),
    .pkt_out_avail    (pkt_avail0),
    .free_outbound    (free_outbound),
    .put_outbound     (put_out0),
    .payload_outbound (payload_out0),
    .free_inbound     (free_in0),
    .put_inbound      (put_inbound),
    .payload_inbound  (payload_inbound),
    .rx_drop          (drop0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_tx(input logic [31:0] p);
    tx_q.push_back(p[31:24]);
    tx_q.push_back(p[23:16]);
    tx_q.push_back(p[15:8]);
    tx_q.push_back(p[7:0]);
  endtask

  task automatic wait_tx_empty(input int budget);
    int k = 0;
    while (tx_q.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    check("tx_drain", tx_q.size(), 0);
  endtask

  // Drives four consecutive inbound bytes; free_inbound must be low while receiving.
  task automatic send_rx(input logic [31:0] p);
    put_inbound = 1'b1;
    for (int b = 3; b >= 0; b--) begin
      payload_inbound = p[8*b +: 8];
      cyc();
      if (b != 0) check("rx_free_low", free_in, 1'b0);
    end
    put_inbound = 1'b0;
  endtask

  // Output monitor: every strobe must match the head of its scoreboard queue.
  always @(negedge clock) begin
    if (put_out === 1'b1) begin
      check("tx_pending", tx_q.size() != 0, 1'b1);
      if (tx_q.size() != 0) check("tx_byte", payload_out, tx_q.pop_front());
    end
    if (pkt_avail === 1'b1) begin
      check("rx_pending", rx_q.size() != 0, 1'b1);
      if (rx_q.size() != 0) check("rx_pkt", pkt_out, rx_q.pop_front());
    end
    if (pkt_avail0 === 1'b1) begin
      check("rx0_pending", rx0_q.size() != 0, 1'b1);
      if (rx0_q.size() != 0) check("rx0_pkt", pkt_out0, rx0_q.pop_front());
    end
    if (drop === 1'b1) n_drop++;
    if (drop0 === 1'b1) n_drop0++;
    if (put_out0 === 1'b1) n_put0++;
  end

  initial begin
    pk[0] = 32'h11223344;
    pk[1] = 32'h55667788;
    pk[2] = 32'h99AABBCC;
    pk[3] = 32'hDDEEFF01;
    pk[4] = 32'h0F1E2D3C;
    pk[5] = 32'h4B5A6978;
    reset_b         = 1'b0;
    pkt_in          = '0;
    pkt_in_avail    = 1'b0;
    free_outbound   = 1'b0;
    put_inbound     = 1'b0;
    payload_inbound = '0;

    // Reset state
    repeat (3) cyc();
    check("rst_full", cq_full, 1'b0);
    check("rst_put", put_out, 1'b0);
    check("rst_payload", payload_out, 8'h00);
    check("rst_pkt_out", pkt_out, 32'h0);
    check("rst_avail", pkt_avail, 1'b0);
    check("rst_drop", drop, 1'b0);
    check("rst_free", free_in, 1'b0);
    reset_b = 1'b1;
    cyc();
    check("free_after_rst", free_in, 1'b1);

    // Single packet out: 4 byte strobes, then low
    free_outbound = 1'b1;
    pkt_in        = 32'h12ABCDEF;
    pkt_in_avail  = 1'b1;
    push_tx(32'h12ABCDEF);
    cyc();
    pkt_in_avail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("tx_put_high", put_out, 1'b1);
    end
    cyc();
    check("tx_put_low", put_out, 1'b0);
    check("tx_single_done", tx_q.size(), 0);
    free_outbound = 1'b0;

    // Fill to full, drop the 5th, then pop+write while full rejects the write
    for (int i = 0; i < 4; i++) begin
      pkt_in       = pk[i];
      pkt_in_avail = 1'b1;
      push_tx(pk[i]);
      cyc();
      check("fill_full", cq_full, (i == 3) ? 1'b1 : 1'b0);
    end
    pkt_in = pk[4];
    cyc();
    check("full_drop5", cq_full, 1'b1);
    check("no_tx_while_busy", put_out, 1'b0);
    pkt_in        = pk[5];
    free_outbound = 1'b1;
    cyc();
    pkt_in_avail = 1'b0;
    check("pop_full_write", cq_full, 1'b0);
    check("pop_put", put_out, 1'b1);
    wait_tx_empty(40);
    check("drain_put_low", put_out, 1'b0);
    repeat (8) cyc();
    check("drain_no_extra", tx_q.size(), 0);
    free_outbound = 1'b0;

    // Inbound packet for this node
    check("rx_idle_free", free_in, 1'b1);
    rx_q.push_back(32'h13010203);
    rx0_q.push_back(32'h13010203);
    send_rx(32'h13010203);
    check("rx_avail", pkt_avail, 1'b1);
    check("rx_out", pkt_out, 32'h13010203);
    check("rx_free_back", free_in, 1'b1);
    check("rx_no_drop", drop, 1'b0);
    check("rx0_avail", pkt_avail0, 1'b1);
    cyc();
    check("rx_avail_pulse", pkt_avail, 1'b0);
    check("rx_hold", pkt_out, 32'h13010203);

    // Inbound packet for another node
    rx0_q.push_back(32'h15AABBCC);
    send_rx(32'h15AABBCC);
    check("wrong_dest_drop", drop, 1'b1);
    check("wrong_dest_avail", pkt_avail, 1'b0);
    check("wrong_dest_hold", pkt_out, 32'h13010203);
    check("nofilter_avail", pkt_avail0, 1'b1);
    check("nofilter_no_drop", drop0, 1'b0);
    cyc();
    check("drop_pulse", drop, 1'b0);
    check("nofilter_out", pkt_out0, 32'h15AABBCC);

    // Abort after byte 1, then a full packet
    put_inbound     = 1'b1;
    payload_inbound = 8'h23;
    cyc();
    payload_inbound = 8'h11;
    cyc();
    put_inbound = 1'b0;
    cyc();
    check("abort_drop", drop, 1'b1);
    check("abort_free", free_in, 1'b1);
    check("abort_avail", pkt_avail, 1'b0);
    check("abort_drop0", drop0, 1'b1);
    cyc();
    check("abort_pulse", drop, 1'b0);
    rx_q.push_back(32'h33445566);
    rx0_q.push_back(32'h33445566);
    send_rx(32'h33445566);
    check("after_abort_avail", pkt_avail, 1'b1);
    check("after_abort_out", pkt_out, 32'h33445566);
    cyc();

    // Reset during outbound byte 2, with a second packet still queued
    free_outbound = 1'b1;
    pkt_in        = 32'hA1B2C3D4;
    pkt_in_avail  = 1'b1;
    cyc();
    pkt_in = 32'h55667788;
    cyc();
    pkt_in_avail = 1'b0;
    check("rst_tx_b0", put_out, 1'b1);
    tx_q.push_back(8'hA1);
    tx_q.push_back(8'hB2);
    tx_q.push_back(8'hC3);
    cyc();
    cyc();
    reset_b = 1'b0;
    cyc();
    check("midrst_put", put_out, 1'b0);
    check("midrst_full", cq_full, 1'b0);
    check("midrst_payload", payload_out, 8'h00);
    check("midrst_pkt_out", pkt_out, 32'h0);
    check("midrst_free", free_in, 1'b0);
    reset_b = 1'b1;
    cyc();
    check("midrst_free_up", free_in, 1'b1);
    repeat (8) begin
      cyc();
      check("midrst_fifo_empty", put_out, 1'b0);
    end
    check("midrst_sb", tx_q.size(), 0);
    free_outbound = 1'b0;

    // Totals
    check("drop_count", n_drop, 2);
    check("drop0_count", n_drop0, 1);
    check("rx_sb_empty", rx_q.size(), 0);
    check("rx0_sb_empty", rx0_q.size(), 0);
    check("dut0_no_tx", n_put0, 0);
    check("dut0_payload", payload_out0, 8'h00);
    check("dut0_full", cq_full0, 1'b0);
    check("dut0_free", free_in0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
